// File: rtl/cam_cfg_sequencer.sv
// Camera register-table walker feeding the I2C master.
// One write (plus optional read-back) per entry, with retries and delays.
module cam_cfg_sequencer #(
    parameter logic [7:0] DEV_ADDR   = 8'h78,
    parameter int         TABLE_LEN  = 64,
    parameter int         VERIFY     = 1,
    parameter int         RETRY_MAX  = 3,
    parameter int         DELAY_UNIT = 800,
    parameter int         XFER_TO    = 4096
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cfg_start,
    output logic [7:0]  tbl_addr,
    input  logic [23:0] tbl_data,
    output logic        iic_start_en,
    output logic        iic_wr_rd_flag,
    output logic [7:0]  iic_dev_addr,
    output logic [15:0] iic_register,
    output logic [7:0]  iic_data_byte,
    input  logic        iic_busy,
    input  logic        iic_err,
    input  logic [7:0]  iic_rd_data,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_fail,
    output logic [7:0]  fail_idx
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_HI,
        S_WAIT_LO, S_CHECK, S_DELAY, S_DONE, S_FAIL
    } state_t;

    localparam logic [7:0]  LAST_IDX = 8'(TABLE_LEN - 1);
    localparam logic [7:0]  RMAX     = 8'(RETRY_MAX);
    localparam logic [31:0] TO_LAST  = 32'(XFER_TO - 1);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  retry_q, retry_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] reg_q, reg_d;
    logic [7:0]  val_q, val_d;
    logic        phase_q, phase_d;
    logic        err_q, err_d;
    logic [7:0]  rd_q, rd_d;
    logic        gap_q, gap_d;
    logic [7:0]  fidx_q, fidx_d;
    logic        retry_req, advance;

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            reg_q   <= '0;
            val_q   <= '0;
            phase_q <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            gap_q   <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
            phase_q <= phase_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            gap_q   <= gap_d;
            fidx_q  <= fidx_d;
        end
    end

    // Next-state: table walk, transfer tracking, retry and advance
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        cnt_d     = cnt_q;
        reg_d     = reg_q;
        val_d     = val_q;
        phase_d   = phase_q;
        err_d     = err_q;
        rd_d      = rd_q;
        gap_d     = gap_q;
        fidx_d    = fidx_q;
        retry_req = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (cfg_start) begin
                    state_d = S_FETCH;
                    idx_d   = '0;
                    retry_d = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                reg_d   = tbl_data[23:8];
                val_d   = tbl_data[7:0];
                phase_d = 1'b0;
                gap_d   = 1'b0;
                if (tbl_data[23:8] == 16'hFFFF) begin
                    if (tbl_data[7:0] == 8'd0) begin
                        advance = 1'b1;
                    end else begin
                        state_d = S_DELAY;
                        cnt_d   = 32'(tbl_data[7:0]) * 32'(DELAY_UNIT)
                                  - 32'd1;
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (!iic_busy) state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q >= TO_LAST) begin
                    state_d = S_FAIL;
                    fidx_d  = idx_q;
                end else if (iic_busy) begin
                    state_d = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                cnt_d = cnt_q + 32'd1;
                if (!iic_busy) begin
                    state_d = S_CHECK;
                end else if (cnt_q >= TO_LAST) begin
                    state_d = S_FAIL;
                    fidx_d  = idx_q;
                end else begin
                    err_d = err_q | iic_err;
                    rd_d  = iic_rd_data;
                end
            end
            S_CHECK: begin
                if (err_q) begin
                    retry_req = 1'b1;
                end else if (!phase_q) begin
                    if (VERIFY != 0) begin
                        phase_d = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (rd_q != val_q) begin
                    retry_req = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end
            S_DELAY: begin
                if (cnt_q == 32'd0) begin
                    if (gap_q) state_d = S_ISSUE;
                    else advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Retry idles two cycles so the driver is back in idle first
        if (retry_req) begin
            if (retry_q < RMAX) begin
                retry_d = retry_q + 8'd1;
                phase_d = 1'b0;
                gap_d   = 1'b1;
                cnt_d   = 32'd1;
                state_d = S_DELAY;
            end else begin
                state_d = S_FAIL;
                fidx_d  = idx_q;
            end
        end
        if (advance) begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + 8'd1;
                state_d = S_FETCH;
            end
        end
    end

    // Outputs decoded from state; start_en never overlaps busy
    always_comb begin
        iic_start_en   = (state_q == S_ISSUE || state_q == S_WAIT_HI)
                         && !iic_busy;
        cfg_busy       = !(state_q == S_IDLE || state_q == S_DONE
                           || state_q == S_FAIL);
        cfg_done       = (state_q == S_DONE);
        cfg_fail       = (state_q == S_FAIL);
        tbl_addr       = idx_q;
        iic_wr_rd_flag = phase_q;
        iic_dev_addr   = DEV_ADDR;
        iic_register   = reg_q;
        iic_data_byte  = val_q;
        fail_idx       = fidx_q;
    end

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Bench for cam_cfg_sequencer: ROM model, behavioural I2C driver,
// transaction scoreboard of expected writes/reads.
module tb_cam_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [7:0]  tbl_addr;
    logic [23:0] tbl_data;
    logic        iic_start_en, iic_wr_rd_flag;
    logic [7:0]  iic_dev_addr;
    logic [15:0] iic_register;
    logic [7:0]  iic_data_byte;
    logic        iic_busy, iic_err;
    logic [7:0]  iic_rd_data;
    logic        cfg_busy, cfg_done, cfg_fail;
    logic [7:0]  fail_idx;

    always #5 clk = ~clk;

    cam_cfg_sequencer #(
        .DEV_ADDR(8'h78), .TABLE_LEN(4), .VERIFY(1),
        .RETRY_MAX(3), .DELAY_UNIT(8), .XFER_TO(64)
    ) dut (
        .clk_i(clk), .rst_n(rst_n), .cfg_start(cfg_start),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .iic_start_en(iic_start_en), .iic_wr_rd_flag(iic_wr_rd_flag),
        .iic_dev_addr(iic_dev_addr), .iic_register(iic_register),
        .iic_data_byte(iic_data_byte), .iic_busy(iic_busy),
        .iic_err(iic_err), .iic_rd_data(iic_rd_data),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .cfg_fail(cfg_fail), .fail_idx(fail_idx)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Synchronous ROM: {3008,82} {FFFF,03} {4300,30} {3103,03}
    logic [23:0] rom [0:3];
    initial begin
        rom[0] = 24'h3008_82;
        rom[1] = 24'hFFFF_03;
        rom[2] = 24'h4300_30;
        rom[3] = 24'h3103_03;
    end
    always @(posedge clk) tbl_data <= rom[tbl_addr[1:0]];

    // Behavioural I2C driver and slave
    int   txn_count = 0;
    int   reads_done = 0;
    int   nack_from = 1 << 30;
    int   corrupt_until = 0;
    bit   hang = 1'b0;
    int   bcnt;
    logic cur_rd, cur_nack;
    logic [7:0] last_wr, resp;

    always @(posedge clk) begin
        if (!rst_n) begin
            iic_busy    <= 1'b0;
            iic_err     <= 1'b0;
            iic_rd_data <= '0;
            bcnt        <= 0;
        end else if (!iic_busy) begin
            if (iic_start_en && !hang) begin
                iic_busy  <= 1'b1;
                bcnt      <= 5;
                cur_rd    <= iic_wr_rd_flag;
                cur_nack  <= (txn_count >= nack_from);
                txn_count <= txn_count + 1;
                if (iic_wr_rd_flag) begin
                    resp <= (reads_done < corrupt_until) ?
                            (last_wr ^ 8'h01) : last_wr;
                    reads_done <= reads_done + 1;
                end else begin
                    last_wr <= iic_data_byte;
                end
            end
        end else if (bcnt == 0) begin
            iic_busy    <= 1'b0;
            iic_err     <= 1'b0;
            iic_rd_data <= '0;
        end else begin
            bcnt    <= bcnt - 1;
            iic_err <= cur_nack;
            if (cur_rd) iic_rd_data <= resp;
        end
    end

    // Scoreboard of expected transfers, compared on each start
    typedef struct {
        bit         wr_rd;
        logic [15:0] rga;
        logic [7:0]  dat;
        int          gmin;
        int          gmax;
    } exp_t;
    exp_t sb[$];

    int se_run = 0;
    int max_se = 0;
    int quiet = 0;
    int viol = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (iic_start_en && iic_busy) viol++;
            if (iic_start_en) se_run++;
            else se_run = 0;
            if (se_run > max_se) max_se = se_run;
            if (iic_start_en && !iic_busy && !hang && se_run == 1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", 32'(iic_register), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_wr_rd", 32'(iic_wr_rd_flag), 32'(e.wr_rd));
                    chk("sb_reg", 32'(iic_register), 32'(e.rga));
                    chk("sb_data", 32'(iic_data_byte), 32'(e.dat));
                    chk("sb_dev", 32'(iic_dev_addr), 32'h78);
                    chk("sb_gap", 32'(quiet >= e.gmin && quiet <= e.gmax), 1);
                end
                quiet = 0;
            end else if (!iic_busy && !iic_start_en) begin
                quiet++;
            end else if (iic_busy) begin
                quiet = 0;
            end
        end
    end

    localparam int BIG = 1 << 30;

    task automatic push(input bit wr_rd, input logic [15:0] r,
                        input logic [7:0] d, input int gmin, input int gmax);
        exp_t e;
        e.wr_rd = wr_rd;
        e.rga   = r;
        e.dat   = d;
        e.gmin  = gmin;
        e.gmax  = gmax;
        sb.push_back(e);
    endtask

    // Delay entry: 3*8 cycles plus fetch/decode overhead
    task automatic push_tail();
        push(1'b0, 16'h4300, 8'h30, 24, 40);
        push(1'b1, 16'h4300, 8'h30, 0, BIG);
        push(1'b0, 16'h3103, 8'h03, 0, BIG);
        push(1'b1, 16'h3103, 8'h03, 0, BIG);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (cfg_done || cfg_fail) seen = 1'b1;
        end
        if (!seen) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_start_en"}, 32'(iic_start_en), 0);
        chk({tag, "_wr_rd"}, 32'(iic_wr_rd_flag), 0);
        chk({tag, "_dev"}, 32'(iic_dev_addr), 32'h78);
        chk({tag, "_reg"}, 32'(iic_register), 0);
        chk({tag, "_data"}, 32'(iic_data_byte), 0);
        chk({tag, "_addr"}, 32'(tbl_addr), 0);
        chk({tag, "_busy"}, 32'(cfg_busy), 0);
        chk({tag, "_done"}, 32'(cfg_done), 0);
        chk({tag, "_fail"}, 32'(cfg_fail), 0);
        chk({tag, "_fidx"}, 32'(fail_idx), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;

        // Normal walk; a second start mid-walk must be ignored
        push(1'b0, 16'h3008, 8'h82, 0, BIG);
        push(1'b1, 16'h3008, 8'h82, 0, BIG);
        push_tail();
        max_se = 0;
        pulse_start();
        chk("busy_after_start", 32'(cfg_busy), 1);
        repeat (20) @(negedge clk);
        pulse_start();
        wait_end("a_timeout");
        chk("a_done", 32'(cfg_done), 1);
        chk("a_fail", 32'(cfg_fail), 0);
        chk("a_busy", 32'(cfg_busy), 0);
        chk("a_sb_empty", sb.size(), 0);
        chk("a_start_width", 32'(max_se <= 2), 1);

        // One bad read-back, then a good one
        corrupt_until = reads_done + 1;
        push(1'b0, 16'h3008, 8'h82, 0, BIG);
        push(1'b1, 16'h3008, 8'h82, 0, BIG);
        push(1'b0, 16'h3008, 8'h82, 2, BIG);
        push(1'b1, 16'h3008, 8'h82, 0, BIG);
        push_tail();
        pulse_start();
        chk("b_done_cleared", 32'(cfg_done), 0);
        wait_end("b_timeout");
        chk("b_done", 32'(cfg_done), 1);
        chk("b_sb_empty", sb.size(), 0);

        // Permanent NACK on entry 0: four attempts then fail
        nack_from = txn_count;
        push(1'b0, 16'h3008, 8'h82, 0, BIG);
        for (int i = 0; i < 3; i++) push(1'b0, 16'h3008, 8'h82, 2, BIG);
        pulse_start();
        wait_end("c_timeout");
        chk("c_fail", 32'(cfg_fail), 1);
        chk("c_done", 32'(cfg_done), 0);
        chk("c_fidx", 32'(fail_idx), 0);
        chk("c_sb_empty", sb.size(), 0);
        nack_from = BIG;

        // Driver never goes busy: transfer timeout, no retry
        hang = 1'b1;
        pulse_start();
        wait_end("d_timeout");
        chk("d_fail", 32'(cfg_fail), 1);
        chk("d_fidx", 32'(fail_idx), 0);
        chk("d_start_low", 32'(iic_start_en), 0);
        hang = 1'b0;

        // NACK from entry 2 onward: fail index 2
        nack_from = txn_count + 2;
        push(1'b0, 16'h3008, 8'h82, 0, BIG);
        push(1'b1, 16'h3008, 8'h82, 0, BIG);
        push(1'b0, 16'h4300, 8'h30, 24, 40);
        for (int i = 0; i < 3; i++) push(1'b0, 16'h4300, 8'h30, 2, BIG);
        pulse_start();
        wait_end("e_timeout");
        chk("e_fail", 32'(cfg_fail), 1);
        chk("e_fidx", 32'(fail_idx), 2);
        chk("e_sb_empty", sb.size(), 0);
        nack_from = BIG;

        // Reset mid-transfer, then a clean restart from entry 0
        push(1'b0, 16'h3008, 8'h82, 0, BIG);
        pulse_start();
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 200 && !seen; i++) begin
                @(negedge clk);
                if (iic_busy) seen = 1'b1;
            end
            if (!seen) chk("f_busy_timeout", 32'd0, 32'd1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outs("midrst");
        sb.delete();
        rst_n = 1'b1;
        push(1'b0, 16'h3008, 8'h82, 0, BIG);
        push(1'b1, 16'h3008, 8'h82, 0, BIG);
        push_tail();
        pulse_start();
        wait_end("f_timeout");
        chk("f_done", 32'(cfg_done), 1);
        chk("f_sb_empty", sb.size(), 0);

        chk("start_while_busy", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
